// File: rtl/sequence_plot_control_pkg.sv
// Shared definitions for the character sequence plot controller.
//   state_t        : FSM state encoding
//   *_DEF          : default sizes used as parameter defaults by the top
//   clamp_count()  : limits a requested character count to the sequence capacity
package sequence_plot_control_pkg;

    localparam int MAX_CHARS_DEF  = 11;
    localparam int CHAR_W_DEF     = 8;
    localparam int CHAR_PITCH_DEF = 6;
    localparam int X_W_DEF        = 8;
    localparam int Y_W_DEF        = 7;
    localparam int IDX_W          = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ACK   = 3'd2,
        S_BUSY  = 3'd3,
        S_WIPE  = 3'd4,
        S_WWAIT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    function automatic logic [IDX_W-1:0] clamp_count(input logic [IDX_W-1:0] num,
                                                     input logic [IDX_W-1:0] max_n);
        return (num > max_n) ? max_n : num;
    endfunction

endpackage

// File: rtl/sequence_plot_control.sv
// Character sequence sequencer feeding the per-character plot controller.
// Latches a packed character string and issues one plot at a time (code, x/y origin,
// start pulse), waiting for the plotter to go busy and then idle again before the next.
// Also launches a region wipe through the clear engine. seq_done pulses at the end.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   draw_en / wipe_en          start requests, only honoured in S_IDLE (wipe wins)
//   sequence_in                packed chars, char i at [i*CHAR_W +: CHAR_W]
//   num_char                   chars to draw, clamped to MAX_CHARS
//   x_start / y_start          origin of char 0
//   ready_to_start_character   plotter idle flag
//   clear_done                 clear engine completion pulse
//   enable_character_plot      1-cycle plot start
//   char_code/char_x/char_y    registered parameters of the current char
//   enable_clear               1-cycle clear start
//   busy                       not idle
//   seq_done                   1-cycle completion pulse
//
// state   | meaning
// S_IDLE  | waiting for draw_en / wipe_en
// S_ISSUE | plot start pulse for char idx
// S_ACK   | wait for plotter to drop ready (ignore its stale ready)
// S_BUSY  | wait for plotter ready again, then next char or finish
// S_WIPE  | clear start pulse
// S_WWAIT | wait for clear_done
// S_DONE  | seq_done pulse
module sequence_plot_control
    import sequence_plot_control_pkg::*;
#(
    parameter int MAX_CHARS  = MAX_CHARS_DEF,
    parameter int CHAR_W     = CHAR_W_DEF,
    parameter int CHAR_PITCH = CHAR_PITCH_DEF,
    parameter int X_W        = X_W_DEF,
    parameter int Y_W        = Y_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        draw_en,
    input  logic                        wipe_en,
    input  logic [MAX_CHARS*CHAR_W-1:0] sequence_in,
    input  logic [3:0]                  num_char,
    input  logic [X_W-1:0]              x_start,
    input  logic [Y_W-1:0]              y_start,
    input  logic                        ready_to_start_character,
    input  logic                        clear_done,
    output logic                        enable_character_plot,
    output logic [CHAR_W-1:0]           char_code,
    output logic [X_W-1:0]              char_x,
    output logic [Y_W-1:0]              char_y,
    output logic                        enable_clear,
    output logic                        busy,
    output logic                        seq_done
);

    state_t                      state_q, state_d;
    logic [MAX_CHARS*CHAR_W-1:0] seq_q;
    logic [IDX_W-1:0]            n_q, idx_q, idx_next, n_clamped;
    logic                        load, load_first, advance;

    assign n_clamped = clamp_count(num_char, IDX_W'(MAX_CHARS));
    assign idx_next  = idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wipe_en) begin
                    state_d = S_WIPE;
                end else if (draw_en && ready_to_start_character) begin
                    load = 1'b1;
                    if (n_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
                        load_first = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_ACK;
            S_ACK: begin
                if (!ready_to_start_character) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (ready_to_start_character) begin
                    if (idx_next == n_q) begin
                        state_d = S_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_WIPE: state_d = S_WWAIT;
            S_WWAIT: begin
                if (clear_done) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // char_x advances by the pitch on each new char instead of idx*pitch; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            char_code <= '0;
            char_x    <= '0;
            char_y    <= '0;
        end else begin
            if (load) begin
                seq_q <= sequence_in;
                n_q   <= n_clamped;
                idx_q <= '0;
            end
            if (load_first) begin
                char_code <= sequence_in[CHAR_W-1:0];
                char_x    <= x_start;
                char_y    <= y_start;
            end
            if (advance) begin
                idx_q     <= idx_next;
                char_code <= seq_q[int'(idx_next)*CHAR_W +: CHAR_W];
                char_x    <= char_x + X_W'(CHAR_PITCH);
            end
        end
    end

    assign enable_character_plot = (state_q == S_ISSUE);
    assign enable_clear          = (state_q == S_WIPE);
    assign seq_done              = (state_q == S_DONE);
    assign busy                  = (state_q != S_IDLE);

endmodule

// File: tb/tb_sequence_plot_control.sv
// Directed bench for sequence_plot_control with a simple plotter model.
module tb_sequence_plot_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        draw_en, wipe_en, clear_done;
    logic [87:0] sequence_in;
    logic [3:0]  num_char;
    logic [7:0]  x_start;
    logic [6:0]  y_start;
    logic        ready_to_start_character;
    logic        enable_character_plot, enable_clear, busy, seq_done;
    logic [7:0]  char_code;
    logic [7:0]  char_x;
    logic [6:0]  char_y;

    sequence_plot_control dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .draw_en                  (draw_en),
        .wipe_en                  (wipe_en),
        .sequence_in              (sequence_in),
        .num_char                 (num_char),
        .x_start                  (x_start),
        .y_start                  (y_start),
        .ready_to_start_character (ready_to_start_character),
        .clear_done               (clear_done),
        .enable_character_plot    (enable_character_plot),
        .char_code                (char_code),
        .char_x                   (char_x),
        .char_y                   (char_y),
        .enable_clear             (enable_clear),
        .busy                     (busy),
        .seq_done                 (seq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // plotter model: ready drops after it sees a start pulse, stays low plot_len cycles
    int   plot_len = 5;
    int   plot_cnt = 0;
    logic ready_force_low = 1'b0;
    always @(posedge clk) begin
        if (plot_cnt != 0) plot_cnt <= plot_cnt - 1;
        else if (enable_character_plot) plot_cnt <= plot_len;
    end
    assign ready_to_start_character = (plot_cnt == 0) && !ready_force_low;

    logic [7:0] code_q[$];
    logic [7:0] x_q[$];
    logic [6:0] y_q[$];
    int         pcyc_q[$];
    int         done_cnt = 0, done_cyc = 0, clear_cnt = 0, rise_cyc = 0;
    logic       ready_prev = 1'b1;

    always @(negedge clk) begin
        if (enable_character_plot) begin
            code_q.push_back(char_code);
            x_q.push_back(char_x);
            y_q.push_back(char_y);
            pcyc_q.push_back(cyc);
        end
        if (seq_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (enable_clear) clear_cnt = clear_cnt + 1;
        if (ready_to_start_character && !ready_prev) rise_cyc = cyc;
        ready_prev = ready_to_start_character;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_draw(input logic [87:0] seq, input logic [3:0] num,
                              input logic [7:0] xs, input logic [6:0] ys, output int acc);
        tick();
        sequence_in = seq;
        num_char    = num;
        x_start     = xs;
        y_start     = ys;
        draw_en     = 1'b1;
        acc         = cyc + 1;
        tick();
        draw_en     = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > base) break;
            tick();
        end
        check("done_timeout", 32'(done_cnt > base), 32'd1);
    endtask

    logic [87:0] seq;
    int          acc, pbase, dbase, cbase, m;

    initial begin
        rst_n = 1'b0; draw_en = 1'b0; wipe_en = 1'b0; clear_done = 1'b0;
        sequence_in = '0; num_char = '0; x_start = '0; y_start = '0;
        ticks(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plot", 32'(enable_character_plot), 32'd0);
        check("rst_code", 32'(char_code), 32'd0);
        check("rst_x", 32'(char_x), 32'd0);
        check("rst_done", 32'(seq_done), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // 1: three chars, long plotter busy time
        plot_len = 40;
        seq = '0; seq[7:0] = 8'h41; seq[15:8] = 8'h42; seq[23:16] = 8'h43;
        pbase = code_q.size(); dbase = done_cnt;
        start_draw(seq, 4'd3, 8'd10, 7'd20, acc);
        wait_done(dbase, 500);
        ticks(5);
        check("t1_pulses", 32'(code_q.size() - pbase), 32'd3);
        if (code_q.size() - pbase == 3) begin
            check("t1_lat", 32'(pcyc_q[pbase]), 32'(acc));
            check("t1_c0", 32'(code_q[pbase]), 32'h41);
            check("t1_x0", 32'(x_q[pbase]), 32'd10);
            check("t1_y0", 32'(y_q[pbase]), 32'd20);
            check("t1_c1", 32'(code_q[pbase+1]), 32'h42);
            check("t1_x1", 32'(x_q[pbase+1]), 32'd16);
            check("t1_c2", 32'(code_q[pbase+2]), 32'h43);
            check("t1_x2", 32'(x_q[pbase+2]), 32'd22);
            check("t1_y2", 32'(y_q[pbase+2]), 32'd20);
        end
        check("t1_done_once", 32'(done_cnt - dbase), 32'd1);
        check("t1_done_after_rise", 32'(done_cyc - rise_cyc), 32'd1);

        // 2a: zero chars goes straight to done
        plot_len = 3;
        pbase = code_q.size(); dbase = done_cnt;
        start_draw(seq, 4'd0, 8'd0, 7'd0, acc);
        ticks(3);
        check("t2_zero_pulses", 32'(code_q.size() - pbase), 32'd0);
        check("t2_zero_done", 32'(done_cnt - dbase), 32'd1);
        check("t2_zero_done_cyc", 32'(done_cyc), 32'(acc));

        // 2b: 15 requested clamps to 11
        seq = '0;
        for (int i = 0; i < 11; i++) seq[i*8 +: 8] = 8'(i + 1);
        pbase = code_q.size(); dbase = done_cnt;
        start_draw(seq, 4'd15, 8'd0, 7'd5, acc);
        wait_done(dbase, 500);
        ticks(5);
        check("t2_clamp_pulses", 32'(code_q.size() - pbase), 32'd11);
        if (code_q.size() - pbase == 11) begin
            check("t2_last_code", 32'(code_q[pbase+10]), 32'd11);
            check("t2_last_x", 32'(x_q[pbase+10]), 32'd60);
        end

        // 3: wipe wins over draw
        pbase = code_q.size(); dbase = done_cnt; cbase = clear_cnt;
        tick();
        draw_en = 1'b1; wipe_en = 1'b1; num_char = 4'd2;
        tick();
        draw_en = 1'b0; wipe_en = 1'b0;
        ticks(99);
        check("t3_clear_pulse", 32'(clear_cnt - cbase), 32'd1);
        check("t3_no_plot", 32'(code_q.size() - pbase), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_no_done_yet", 32'(done_cnt - dbase), 32'd0);
        clear_done = 1'b1; m = cyc;
        tick();
        clear_done = 1'b0;
        check("t3_done", 32'(done_cnt - dbase), 32'd1);
        check("t3_done_cyc", 32'(done_cyc), 32'(m + 1));
        ticks(3);

        // 4: x wraps mod 256
        seq = '0; seq[7:0] = 8'h30; seq[15:8] = 8'h31; seq[23:16] = 8'h32;
        pbase = code_q.size(); dbase = done_cnt;
        start_draw(seq, 4'd3, 8'd250, 7'd1, acc);
        wait_done(dbase, 500);
        ticks(3);
        check("t4_pulses", 32'(code_q.size() - pbase), 32'd3);
        if (code_q.size() - pbase == 3) begin
            check("t4_x0", 32'(x_q[pbase]), 32'd250);
            check("t4_x1", 32'(x_q[pbase+1]), 32'd0);
            check("t4_x2", 32'(x_q[pbase+2]), 32'd6);
        end

        // 5: draw_en while busy and while plotter not ready are both ignored
        plot_len = 20;
        seq = '0; seq[7:0] = 8'h50; seq[15:8] = 8'h51;
        pbase = code_q.size(); dbase = done_cnt;
        start_draw(seq, 4'd2, 8'd0, 7'd0, acc);
        ticks(10);
        sequence_in = '1; num_char = 4'd9; draw_en = 1'b1;
        tick();
        draw_en = 1'b0;
        wait_done(dbase, 500);
        ticks(5);
        check("t5_busy_pulses", 32'(code_q.size() - pbase), 32'd2);
        if (code_q.size() - pbase == 2) check("t5_latched_code", 32'(code_q[pbase+1]), 32'h51);
        check("t5_done_once", 32'(done_cnt - dbase), 32'd1);
        ready_force_low = 1'b1;
        pbase = code_q.size();
        start_draw(seq, 4'd2, 8'd0, 7'd0, acc);
        ticks(5);
        check("t5_notready_busy", 32'(busy), 32'd0);
        check("t5_notready_pulses", 32'(code_q.size() - pbase), 32'd0);
        ready_force_low = 1'b0;
        ticks(3);
        check("t5_not_queued", 32'(code_q.size() - pbase), 32'd0);

        // 6: async reset in the second char's busy wait
        plot_len = 30;
        seq = '0; seq[7:0] = 8'h61; seq[15:8] = 8'h62; seq[23:16] = 8'h63;
        pbase = code_q.size(); dbase = done_cnt;
        start_draw(seq, 4'd3, 8'd40, 7'd9, acc);
        for (int i = 0; i < 300; i++) begin
            if (code_q.size() - pbase >= 2) break;
            tick();
        end
        check("t6_second_pulse", 32'(code_q.size() - pbase), 32'd2);
        ticks(10);
        check("t6_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_plot", 32'(enable_character_plot), 32'd0);
        check("t6_rst_code", 32'(char_code), 32'd0);
        check("t6_rst_x", 32'(char_x), 32'd0);
        check("t6_rst_y", 32'(char_y), 32'd0);
        check("t6_rst_clear", 32'(enable_clear), 32'd0);
        check("t6_rst_done", 32'(seq_done), 32'd0);
        tick();
        rst_n = 1'b1;
        ticks(60);
        check("t6_no_pulse_after", 32'(code_q.size() - pbase), 32'd2);
        check("t6_no_done_after", 32'(done_cnt - dbase), 32'd0);
        plot_len = 3;
        pbase = code_q.size(); dbase = done_cnt;
        start_draw(seq, 4'd1, 8'd7, 7'd3, acc);
        wait_done(dbase, 200);
        check("t6_redraw_pulses", 32'(code_q.size() - pbase), 32'd1);
        if (code_q.size() - pbase == 1) check("t6_redraw_code", 32'(code_q[pbase]), 32'h61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
